// File: rtl/line_buffer_pkg.sv
// Shared types and helpers for the multi-row line buffer.
// Holds the fill/stream state encoding and the width helper.
package line_buffer_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/line_delay.sv
// One row of delay: circular RAM with external address.
// Read data reflects the contents before this cycle's write.
module line_delay
  import line_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640,
  parameter int AW         = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/line_buffer_array.sv
// Chained row delays presenting one NUM_LINES+1 tap column
// per accepted pixel once all rows are primed.
module line_buffer_array
  import line_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640,
  parameter int NUM_LINES  = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                done_i,
  input  logic                                sof_i,
  input  logic [DATA_WIDTH-1:0]               data_i,
  output logic [(NUM_LINES+1)*DATA_WIDTH-1:0] data_o,
  output logic                                done_o,
  output logic                                primed_o
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(NUM_LINES + 1);
  localparam int TW = (NUM_LINES + 1) * DATA_WIDTH;

  logic [AW-1:0] col_q, col_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic [TW-1:0] data_q, data_d;
  logic          done_q, done_d;
  logic          primed_q, primed_d;

  logic [AW-1:0]         addr;
  logic                  wrap;
  logic [TW-1:0]         taps;
  logic [DATA_WIDTH-1:0] rd [NUM_LINES];
  logic [DATA_WIDTH-1:0] wd [NUM_LINES];

  // A start-of-frame sample lands at column 0 regardless of col_q.
  assign addr = (done_i && sof_i) ? '0 : col_q;
  assign wrap = (col_q == AW'(DEPTH - 1));

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_row
    if (g == 0) begin : g_first
      assign wd[g] = data_i;
    end else begin : g_next
      assign wd[g] = rd[g-1];
    end

    line_delay #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
    ) u_row (
      .clk     (clk),
      .we_i    (done_i),
      .addr_i  (addr),
      .wdata_i (wd[g]),
      .rdata_o (rd[g])
    );
  end

  always_comb begin
    taps = '0;
    taps[DATA_WIDTH-1:0] = data_i;
    for (int k = 0; k < NUM_LINES; k++) begin
      taps[(k+1)*DATA_WIDTH +: DATA_WIDTH] = rd[k];
    end
  end

  always_comb begin
    col_d    = col_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    primed_d = primed_q;
    done_d   = 1'b0;
    data_d   = data_q;
    if (done_i) begin
      if (sof_i) begin
        col_d    = AW'(1);
        cnt_d    = '0;
        state_d  = FILL;
        primed_d = 1'b0;
      end else begin
        col_d = wrap ? '0 : col_q + 1'b1;
        unique case (state_q)
          FILL: begin
            if (wrap) begin
              cnt_d = cnt_q + 1'b1;
              if (cnt_q == CW'(NUM_LINES - 1)) state_d = STREAM;
            end
          end
          STREAM: begin
            done_d   = 1'b1;
            primed_d = 1'b1;
            data_d   = taps;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      cnt_q    <= '0;
      state_q  <= FILL;
      data_q   <= '0;
      done_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      data_q   <= data_d;
      done_q   <= done_d;
      primed_q <= primed_d;
    end
  end

  assign data_o   = data_q;
  assign done_o   = done_q;
  assign primed_o = primed_q;

endmodule

// File: tb/tb_line_buffer_array.sv
// Random and directed stimulus on two geometries, checked
// against a frame-history model of the column taps.
module tb_line_buffer_array;

  logic       clk = 1'b0;
  logic       rst;
  logic       done_i;
  logic       sof_i;
  logic [7:0] data_i;

  logic [23:0] data_a;
  logic        done_a, primed_a;
  logic [15:0] data_b;
  logic        done_b, primed_b;

  always #5 clk = ~clk;

  line_buffer_array #(
    .DATA_WIDTH (8), .DEPTH (5), .NUM_LINES (2)
  ) u_a (
    .clk (clk), .rst (rst), .done_i (done_i), .sof_i (sof_i),
    .data_i (data_i), .data_o (data_a), .done_o (done_a),
    .primed_o (primed_a)
  );

  line_buffer_array #(
    .DATA_WIDTH (8), .DEPTH (3), .NUM_LINES (1)
  ) u_b (
    .clk (clk), .rst (rst), .done_i (done_i), .sof_i (sof_i),
    .data_i (data_i), .data_o (data_b), .done_o (done_b),
    .primed_o (primed_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  hist [$];
  logic [63:0] ea, eb;
  bit          da, db, pa, pb;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Tap k is the pixel k rows back: k*d samples earlier in this frame.
  function automatic logic [63:0] taps(int nl, int d);
    logic [63:0] t;
    int n;
    t = '0;
    n = hist.size() - 1;
    for (int k = 0; k <= nl; k++) t[k*8 +: 8] = hist[n - k*d];
    return t;
  endfunction

  task automatic model_step(bit r, bit d, bit s, logic [7:0] x);
    int n;
    if (r) begin
      hist.delete();
      ea = '0; eb = '0;
      da = 0; db = 0; pa = 0; pb = 0;
    end else if (d) begin
      if (s) hist.delete();
      hist.push_back(x);
      n  = hist.size() - 1;
      da = (n >= 2 * 5);
      db = (n >= 1 * 3);
      if (da) begin pa = 1; ea = taps(2, 5); end
      if (db) begin pb = 1; eb = taps(1, 3); end
      if (s) begin pa = 0; pb = 0; end
    end else begin
      da = 0; db = 0;
    end
  endtask

  task automatic compare();
    check("a_done",   64'(done_a),   64'(da));
    check("a_primed", 64'(primed_a), 64'(pa));
    check("a_data",   64'(data_a),   ea);
    check("b_done",   64'(done_b),   64'(db));
    check("b_primed", 64'(primed_b), 64'(pb));
    check("b_data",   64'(data_b),   eb);
  endtask

  task automatic cyc(bit r, bit d, bit s, logic [7:0] x);
    @(negedge clk);
    compare();
    rst = r; done_i = d; sof_i = s; data_i = x;
    model_step(r, d, s, x);
  endtask

  initial begin
    rst = 1'b1; done_i = 1'b0; sof_i = 1'b0; data_i = '0;
    model_step(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) cyc(0, 1, 0, 8'(i));
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) begin
        for (int g = 0; g < 3; g++) cyc(0, 0, 0, 8'($urandom_range(0, 255)));
      end
      cyc(0, 1, 0, 8'(21 + i));
    end
    cyc(0, 1, 0, 8'(40));
    cyc(0, 1, 0, 8'(41));
    cyc(0, 1, 1, 8'(100));
    for (int i = 1; i <= 14; i++) cyc(0, 1, 0, 8'(100 + i));
    cyc(0, 0, 1, 8'(200));
    cyc(0, 1, 0, 8'(115));
    cyc(1, 1, 0, 8'(77));
    for (int i = 1; i <= 15; i++) cyc(0, 1, 0, 8'(i));
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 9) < 7,
          $urandom_range(0, 59) == 0,
          8'($urandom_range(0, 255)));
    end
    @(negedge clk);
    compare();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
